// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the iterative divider: state codes and the
// quotient pattern returned on a divide by zero.
package div_ctrl_pkg;

  typedef logic [2:0] div_state_t;

  localparam div_state_t DIV_IDLE = 3'd0;
  localparam div_state_t DIV_PREP = 3'd1;
  localparam div_state_t DIV_CALC = 3'd2;
  localparam div_state_t DIV_FIX  = 3'd3;
  localparam div_state_t DIV_DONE = 3'd4;

  // Widest operand the all-ones constant covers; users slice it down to WIDTH.
  localparam int DIV_MAX_W = 64;

  // Quotient reported when the divisor is zero.
  localparam logic [DIV_MAX_W-1:0] DIV_ZERO_Q = '1;

endpackage

// File: rtl/div_core.sv
// Unsigned radix-2 restoring divide datapath. One quotient bit per step:
// the partial remainder absorbs the next dividend bit from the top of the
// quotient shift register, and the divisor is subtracted when it fits.
module div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             fits;

  // Trial subtraction; the borrow out of the extra top bit says the divisor did not fit.
  always_comb begin
    trial = {rem_q, quo_q[WIDTH-1]};
    diff  = trial - {1'b0, dvs_q};
    fits  = ~diff[WIDTH];
  end

  // Load clears the remainder and parks the dividend in the quotient register; step shifts one bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
    end else if (step) begin
      rem_q <= fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
      quo_q <= {quo_q[WIDTH-2:0], fits};
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/div_ctrl.sv
// Iterative DIV/DIVU sequencer for the EXE stage. Owns the FSM, the
// iteration counter, the sign fix-up and the accept/flush handshake; the
// shift/subtract loop lives in div_core. Quotient goes to LO, remainder to HI.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             div_sign,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  input  logic             ack,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo_out,
  output logic [WIDTH-1:0] hi_out,
  output logic             lo_we,
  output logic             hi_we,
  output logic             div_zero
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  div_state_t       state;
  logic [CNT_W-1:0] counter;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             sign_reg;
  logic             q_neg;
  logic             r_neg;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] core_quo;
  logic [WIDTH-1:0] core_rem;
  logic             accept_new;

  // Magnitudes of the latched operands; only a signed divide looks at the top bit.
  always_comb begin
    a_neg = sign_reg & a_reg[WIDTH-1];
    b_neg = sign_reg & b_reg[WIDTH-1];
    abs_a = a_neg ? -a_reg : a_reg;
    abs_b = b_neg ? -b_reg : b_reg;
  end

  // A new divide is taken from IDLE, or from DONE when the old result is accepted the same cycle.
  assign accept_new = start & ~flush & ((state == DIV_IDLE) | ((state == DIV_DONE) & ack));

  div_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (state == DIV_PREP),
    .step     (state == DIV_CALC),
    .dividend (abs_a),
    .divisor  (abs_b),
    .quotient (core_quo),
    .remainder(core_rem)
  );

  // Sequencer: flush wins everywhere; results are written only when entering DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= DIV_IDLE;
      counter  <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      sign_reg <= 1'b0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      lo_out   <= '0;
      hi_out   <= '0;
      div_zero <= 1'b0;
    end else if (flush) begin
      state    <= DIV_IDLE;
      div_zero <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (accept_new) begin
            state    <= DIV_PREP;
            a_reg    <= dividend;
            b_reg    <= divisor;
            sign_reg <= div_sign;
          end
        end
        DIV_PREP: begin
          q_neg <= a_neg ^ b_neg;
          r_neg <= a_neg;
          if (b_reg == '0) begin
            state    <= DIV_DONE;
            lo_out   <= DIV_ZERO_Q[WIDTH-1:0];
            hi_out   <= a_reg;
            div_zero <= 1'b1;
          end else begin
            state   <= DIV_CALC;
            counter <= '0;
          end
        end
        DIV_CALC: begin
          counter <= counter + CNT_W'(1);
          if (counter == LAST_STEP) begin
            state <= DIV_FIX;
          end
        end
        DIV_FIX: begin
          state    <= DIV_DONE;
          lo_out   <= q_neg ? -core_quo : core_quo;
          hi_out   <= r_neg ? -core_rem : core_rem;
          div_zero <= 1'b0;
        end
        DIV_DONE: begin
          if (ack) begin
            div_zero <= 1'b0;
            if (accept_new) begin
              state    <= DIV_PREP;
              a_reg    <= dividend;
              b_reg    <= divisor;
              sign_reg <= div_sign;
            end else begin
              state <= DIV_IDLE;
            end
          end
        end
        default: begin
          state <= DIV_IDLE;
        end
      endcase
    end
  end

  assign busy  = (state == DIV_PREP) | (state == DIV_CALC) | (state == DIV_FIX);
  assign done  = (state == DIV_DONE);
  assign lo_we = done & ack & ~flush;
  assign hi_we = done & ack & ~flush;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: latency, signed/unsigned results, divide by
// zero, overflow, flush, result hold, back-to-back issue and async reset.
module tb_div_ctrl;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             start;
  logic             div_sign;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             flush;
  logic             ack;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] lo_out;
  logic [WIDTH-1:0] hi_out;
  logic             lo_we;
  logic             hi_we;
  logic             div_zero;

  int nvec  = 0;
  int nfail = 0;

  div_ctrl #(
    .WIDTH(WIDTH),
    .CNT_W(6)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .div_sign(div_sign),
    .dividend(dividend),
    .divisor (divisor),
    .flush   (flush),
    .ack     (ack),
    .busy    (busy),
    .done    (done),
    .lo_out  (lo_out),
    .hi_out  (hi_out),
    .lo_we   (lo_we),
    .hi_we   (hi_we),
    .div_zero(div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a divide for one cycle (cycle 0) and count cycles until done; -1 on timeout.
  task automatic run_div(input logic sgn, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, output int cyc);
    start    = 1'b1;
    div_sign = sgn;
    dividend = a;
    divisor  = b;
    tick();
    start = 1'b0;
    cyc   = 1;
    while (!done && cyc < 100) begin
      tick();
      cyc++;
    end
    if (!done) cyc = -1;
  endtask

  // Accept the current result for one cycle and return to idle.
  task automatic accept();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic test_reset();
    nvec++;
    if ({busy, done, lo_we, hi_we, div_zero} !== 5'b0) begin
      nfail++;
      $display("[TB] FAIL reset_flags: got %b expected 00000", {busy, done, lo_we, hi_we, div_zero});
    end
    nvec++;
    if ({lo_out, hi_out} !== 64'h0) begin
      nfail++;
      $display("[TB] FAIL reset_result: got lo=%h hi=%h expected 0/0", lo_out, hi_out);
    end
  endtask

  task automatic test_divu();
    int cyc;
    run_div(1'b0, 32'd100, 32'd7, cyc);
    nvec++;
    if (cyc !== 35) begin
      nfail++;
      $display("[TB] FAIL divu_latency: got %0d expected 35", cyc);
    end
    nvec++;
    if (lo_out !== 32'd14 || hi_out !== 32'd2) begin
      nfail++;
      $display("[TB] FAIL divu_100_7: got lo=%h hi=%h expected 0000000e/00000002", lo_out, hi_out);
    end
    nvec++;
    if (busy !== 1'b0 || div_zero !== 1'b0 || lo_we !== 1'b0) begin
      nfail++;
      $display("[TB] FAIL divu_done_flags: got busy=%b dz=%b we=%b expected 0/0/0", busy, div_zero, lo_we);
    end
    ack = 1'b1;
    #1;
    nvec++;
    if (lo_we !== 1'b1 || hi_we !== 1'b1) begin
      nfail++;
      $display("[TB] FAIL divu_we: got lo_we=%b hi_we=%b expected 1/1", lo_we, hi_we);
    end
    tick();
    ack = 1'b0;
    nvec++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      nfail++;
      $display("[TB] FAIL divu_release: got done=%b busy=%b expected 0/0", done, busy);
    end
  endtask

  task automatic test_signed();
    int cyc;
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, cyc);
    nvec++;
    if (cyc !== 35 || lo_out !== 32'hFFFF_FFFD || hi_out !== 32'hFFFF_FFFF) begin
      nfail++;
      $display("[TB] FAIL div_m7_2: got cyc=%0d lo=%h hi=%h expected 35 fffffffd/ffffffff", cyc, lo_out, hi_out);
    end
    accept();
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, cyc);
    nvec++;
    if (lo_out !== 32'hFFFF_FFFD || hi_out !== 32'd1) begin
      nfail++;
      $display("[TB] FAIL div_7_m2: got lo=%h hi=%h expected fffffffd/00000001", lo_out, hi_out);
    end
    accept();
    run_div(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, cyc);
    nvec++;
    if (lo_out !== 32'd14 || hi_out !== 32'hFFFF_FFFE) begin
      nfail++;
      $display("[TB] FAIL div_m100_m7: got lo=%h hi=%h expected 0000000e/fffffffe", lo_out, hi_out);
    end
    accept();
    run_div(1'b0, 32'hFFFF_FFF9, 32'd2, cyc);
    nvec++;
    if (lo_out !== 32'h7FFF_FFFC || hi_out !== 32'd1) begin
      nfail++;
      $display("[TB] FAIL divu_big_2: got lo=%h hi=%h expected 7ffffffc/00000001", lo_out, hi_out);
    end
    accept();
  endtask

  task automatic test_overflow_and_zero();
    int cyc;
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    nvec++;
    if (lo_out !== 32'h8000_0000 || hi_out !== 32'd0) begin
      nfail++;
      $display("[TB] FAIL div_overflow: got lo=%h hi=%h expected 80000000/00000000", lo_out, hi_out);
    end
    accept();
    run_div(1'b0, 32'd5, 32'd0, cyc);
    nvec++;
    if (cyc !== 2) begin
      nfail++;
      $display("[TB] FAIL divzero_latency: got %0d expected 2", cyc);
    end
    nvec++;
    if (lo_out !== 32'hFFFF_FFFF || hi_out !== 32'd5 || div_zero !== 1'b1) begin
      nfail++;
      $display("[TB] FAIL divzero_result: got lo=%h hi=%h dz=%b expected ffffffff/00000005/1", lo_out, hi_out, div_zero);
    end
    accept();
    nvec++;
    if (div_zero !== 1'b0) begin
      nfail++;
      $display("[TB] FAIL divzero_clear: got %b expected 0", div_zero);
    end
  endtask

  task automatic test_flush();
    int cyc;
    start    = 1'b1;
    div_sign = 1'b0;
    dividend = 32'd999;
    divisor  = 32'd4;
    tick();
    start = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    #1;
    nvec++;
    if (lo_we !== 1'b0 || busy !== 1'b1) begin
      nfail++;
      $display("[TB] FAIL flush_c10: got we=%b busy=%b expected 0/1", lo_we, busy);
    end
    tick();
    flush = 1'b0;
    nvec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      nfail++;
      $display("[TB] FAIL flush_c11: got busy=%b done=%b expected 0/0", busy, done);
    end
    tick();
    run_div(1'b0, 32'd1000, 32'd10, cyc);
    nvec++;
    if (cyc !== 35 || lo_out !== 32'd100 || hi_out !== 32'd0) begin
      nfail++;
      $display("[TB] FAIL flush_restart: got cyc=%0d lo=%h hi=%h expected 35 00000064/00000000", cyc, lo_out, hi_out);
    end
    ack   = 1'b1;
    flush = 1'b1;
    #1;
    nvec++;
    if (lo_we !== 1'b0 || hi_we !== 1'b0) begin
      nfail++;
      $display("[TB] FAIL flush_in_done_we: got %b%b expected 00", lo_we, hi_we);
    end
    tick();
    ack   = 1'b0;
    flush = 1'b0;
    nvec++;
    if (done !== 1'b0) begin
      nfail++;
      $display("[TB] FAIL flush_in_done: got done=%b expected 0", done);
    end
    start = 1'b1;
    flush = 1'b1;
    tick();
    start = 1'b0;
    flush = 1'b0;
    nvec++;
    if (busy !== 1'b0) begin
      nfail++;
      $display("[TB] FAIL flush_with_start: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    run_div(1'b0, 32'd50, 32'd3, cyc);
    start    = 1'b1;
    dividend = 32'd1234;
    divisor  = 32'd9;
    for (int i = 0; i < 5; i++) begin
      tick();
      nvec++;
      if (done !== 1'b1 || busy !== 1'b0 || lo_out !== 32'd16 || hi_out !== 32'd2) begin
        nfail++;
        $display("[TB] FAIL hold_%0d: got done=%b busy=%b lo=%h hi=%h expected 1/0 00000010/00000002",
                 i, done, busy, lo_out, hi_out);
      end
    end
    dividend = 32'd77;
    divisor  = 32'd5;
    ack      = 1'b1;
    #1;
    nvec++;
    if (lo_we !== 1'b1) begin
      nfail++;
      $display("[TB] FAIL b2b_we: got %b expected 1", lo_we);
    end
    tick();
    ack   = 1'b0;
    start = 1'b0;
    cyc   = 1;
    while (!done && cyc < 100) begin
      tick();
      cyc++;
    end
    nvec++;
    if (cyc !== 35 || lo_out !== 32'd15 || hi_out !== 32'd2) begin
      nfail++;
      $display("[TB] FAIL b2b_second: got cyc=%0d lo=%h hi=%h expected 35 0000000f/00000002", cyc, lo_out, hi_out);
    end
  endtask

  task automatic test_async_reset();
    accept();
    start    = 1'b1;
    dividend = 32'd1000;
    divisor  = 32'd7;
    tick();
    start = 1'b0;
    repeat (10) tick();
    #2;
    rst = 1'b1;
    #1;
    nvec++;
    if (busy !== 1'b0 || done !== 1'b0 || lo_out !== 32'd0 || hi_out !== 32'd0) begin
      nfail++;
      $display("[TB] FAIL async_reset: got busy=%b done=%b lo=%h hi=%h expected 0/0 0/0", busy, done, lo_out, hi_out);
    end
    tick();
    rst = 1'b0;
    tick();
    nvec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      nfail++;
      $display("[TB] FAIL post_reset_idle: got busy=%b done=%b expected 0/0", busy, done);
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    div_sign = 1'b0;
    dividend = '0;
    divisor  = '0;
    flush    = 1'b0;
    ack      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    tick();
    test_divu();
    test_signed();
    test_overflow_and_zero();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
